// File: rtl/uc_multiciclo_pila_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, FSM states, error codes.
package uc_multiciclo_pila_pkg;

  // Exact-match opcodes; the wildcard classes (ALU, LOAD, OUT indirect) live in the decoder
  localparam logic [5:0] OP_JMP   = 6'b001001;
  localparam logic [5:0] OP_JZ    = 6'b001010;
  localparam logic [5:0] OP_JNZ   = 6'b001011;
  localparam logic [5:0] OP_JREL  = 6'b011001;
  localparam logic [5:0] OP_IN    = 6'b001100;
  localparam logic [5:0] OP_OUTR  = 6'b001101;
  localparam logic [5:0] OP_OUTI  = 6'b001110;
  localparam logic [5:0] OP_CALL  = 6'b011010;
  localparam logic [5:0] OP_RET   = 6'b011011;
  localparam logic [5:0] OP_HALT  = 6'b011100;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/uc_multiciclo_pila_ret_stack.sv
// Return-address stack: push on CALL, pop on RET, top-of-stack read combinationally.
module uc_multiciclo_pila_ret_stack #(
  parameter int unsigned PC_W        = 10,
  parameter int unsigned STACK_DEPTH = 8,
  localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1),
  localparam int unsigned AW         = $clog2(STACK_DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_data,
  output logic [PC_W-1:0] o_top,
  output logic            o_full,
  output logic            o_empty
);

  logic [SP_W-1:0] r_sp;
  logic [PC_W-1:0] r_mem [STACK_DEPTH];
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_top_idx;

  assign o_full    = (r_sp == SP_W'(STACK_DEPTH));
  assign o_empty   = (r_sp == '0);
  assign w_wr_idx  = AW'(r_sp);
  assign w_top_idx = AW'(r_sp - SP_W'(1));
  assign o_top     = o_empty ? '0 : r_mem[w_top_idx];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sp <= '0;
    end else if (i_push && !o_full) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  // Storage is deliberately left unreset; only sp defines what is valid
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/uc_multiciclo_pila.sv
// Multi-cycle control unit: opcode decode, RUN/STALL/HALT FSM with I/O stall timeout, return stack.
module uc_multiciclo_pila
  import uc_multiciclo_pila_pkg::*;
#(
  parameter int unsigned NPORTS      = 4,
  parameter int unsigned PC_W        = 10,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned TIMEOUT     = 255,
  localparam int unsigned PSW        = $clog2(NPORTS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [5:0]        i_opcode,
  input  logic              i_z,
  input  logic [PSW-1:0]    i_puerto1,
  input  logic [PSW-1:0]    i_puerto2,
  input  logic [PC_W-1:0]   i_pc_ret,
  input  logic              i_in_valid,
  input  logic              i_out_ack,
  output logic [2:0]        o_op,
  output logic              o_pc_en,
  output logic              o_s_inc,
  output logic              o_s_inm,
  output logic              o_s_rel,
  output logic              o_s_ret,
  output logic              o_selentrada,
  output logic              o_selsalida,
  output logic              o_we3,
  output logic              o_in_ack,
  output logic [NPORTS-1:0] o_out_en,
  output logic [PC_W-1:0]   o_ret_addr,
  output logic              o_stack_empty,
  output logic              o_stack_full,
  output logic              o_halted,
  output logic [1:0]        o_err_code
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_err;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_err_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_wait;
  logic             w_halt_req;
  logic [1:0]       w_halt_err;

  uc_multiciclo_pila_ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (i_pc_ret),
    .o_top   (o_ret_addr),
    .o_full  (o_stack_full),
    .o_empty (o_stack_empty)
  );

  assign o_op       = i_opcode[2:0];
  assign o_halted   = (r_state == ST_HALT);
  assign o_err_code = r_err;

  // Decode plus next-state; nothing is decoded while in reset or HALT
  always_comb begin
    o_pc_en      = 1'b0;
    o_s_inc      = 1'b1;
    o_s_inm      = 1'b0;
    o_s_rel      = 1'b0;
    o_s_ret      = 1'b0;
    o_selentrada = 1'b0;
    o_selsalida  = 1'b0;
    o_we3        = 1'b0;
    o_in_ack     = 1'b0;
    o_out_en     = '0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_wait       = 1'b0;
    w_halt_req   = 1'b0;
    w_halt_err   = r_err;
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_err_nxt    = r_err;

    if (i_reset && (r_state != ST_HALT)) begin
      o_pc_en = 1'b1;
      casez (i_opcode)
        6'b??0???: o_we3 = 1'b1;
        6'b??1000: begin
          o_we3   = 1'b1;
          o_s_inm = 1'b1;
        end
        OP_JMP:  o_s_inc = 1'b0;
        OP_JZ:   o_s_inc = !i_z;
        OP_JNZ:  o_s_inc = i_z;
        OP_JREL: o_s_rel = 1'b1;
        OP_IN: begin
          o_selentrada = 1'b1;
          if (i_in_valid) begin
            o_we3    = 1'b1;
            o_in_ack = 1'b1;
          end else begin
            o_pc_en = 1'b0;
            w_wait  = 1'b1;
          end
        end
        OP_OUTR, OP_OUTI, 6'b??1111: begin
          o_selsalida = (i_opcode != OP_OUTI);
          o_out_en    = (i_opcode == OP_OUTR || i_opcode == OP_OUTI) ?
                        (NPORTS'(1) << i_puerto1) : (NPORTS'(1) << i_puerto2);
          o_pc_en     = i_out_ack;
          w_wait      = !i_out_ack;
        end
        OP_CALL: begin
          if (!o_stack_full) begin
            w_push  = 1'b1;
            o_s_inc = 1'b0;
          end else begin
            o_pc_en    = 1'b0;
            w_halt_req = 1'b1;
            w_halt_err = ERR_OVF;
          end
        end
        OP_RET: begin
          if (!o_stack_empty) begin
            w_pop   = 1'b1;
            o_s_inc = 1'b0;
            o_s_ret = 1'b1;
          end else begin
            o_pc_en    = 1'b0;
            w_halt_req = 1'b1;
            w_halt_err = ERR_UNF;
          end
        end
        OP_HALT: begin
          o_pc_en    = 1'b0;
          w_halt_req = 1'b1;
        end
        default: ;
      endcase

      // Stall counter only advances on cycles spent in STALL without completion
      if (w_halt_req) begin
        w_state_nxt = ST_HALT;
        w_cnt_nxt   = '0;
        w_err_nxt   = w_halt_err;
      end else if (w_wait) begin
        if (r_state == ST_RUN) begin
          w_state_nxt = ST_STALL;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if ((TIMEOUT != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT))) begin
            w_state_nxt = ST_HALT;
            w_cnt_nxt   = '0;
            w_err_nxt   = ERR_TMO;
          end
        end
      end else begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_uc_multiciclo_pila.sv
// Directed bench: decode table on a depth-8/timeout-4 unit, stack and stall sequences on it and a depth-2 unit.
module tb_uc_multiciclo_pila;

  localparam int unsigned PC_W = 10;
  localparam logic [5:0] NOP  = 6'b011101;
  localparam logic [5:0] ALU  = 6'b000101;
  localparam logic [5:0] CALL = 6'b011010;
  localparam logic [5:0] RET  = 6'b011011;
  localparam logic [5:0] IN   = 6'b001100;
  localparam logic [5:0] OUTR = 6'b001101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode;
  logic z;
  logic [1:0] p1, p2;
  logic [PC_W-1:0] pc_ret;
  logic in_valid, out_ack;

  logic [2:0] a_op, b_op;
  logic a_pc_en, a_s_inc, a_s_inm, a_s_rel, a_s_ret, a_selin, a_selout, a_we3, a_in_ack;
  logic b_pc_en, b_s_inc, b_s_inm, b_s_rel, b_s_ret, b_selin, b_selout, b_we3, b_in_ack;
  logic [3:0] a_out_en, b_out_en;
  logic [PC_W-1:0] a_ret, b_ret;
  logic a_empty, a_full, a_halted, b_empty, b_full, b_halted;
  logic [1:0] a_err, b_err;

  int n_err = 0;
  int n_chk = 0;

  typedef struct packed {
    logic [5:0]  opcode;
    logic        z;
    logic [1:0]  p1;
    logic [1:0]  p2;
    logic        in_valid;
    logic        out_ack;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  uc_multiciclo_pila #(.NPORTS(4), .PC_W(PC_W), .STACK_DEPTH(8), .TIMEOUT(4)) u_dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_opcode(opcode), .i_z(z), .i_puerto1(p1), .i_puerto2(p2),
    .i_pc_ret(pc_ret), .i_in_valid(in_valid), .i_out_ack(out_ack),
    .o_op(a_op), .o_pc_en(a_pc_en), .o_s_inc(a_s_inc), .o_s_inm(a_s_inm), .o_s_rel(a_s_rel),
    .o_s_ret(a_s_ret), .o_selentrada(a_selin), .o_selsalida(a_selout), .o_we3(a_we3),
    .o_in_ack(a_in_ack), .o_out_en(a_out_en), .o_ret_addr(a_ret), .o_stack_empty(a_empty),
    .o_stack_full(a_full), .o_halted(a_halted), .o_err_code(a_err)
  );

  uc_multiciclo_pila #(.NPORTS(4), .PC_W(PC_W), .STACK_DEPTH(2), .TIMEOUT(0)) u_dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_opcode(opcode), .i_z(z), .i_puerto1(p1), .i_puerto2(p2),
    .i_pc_ret(pc_ret), .i_in_valid(in_valid), .i_out_ack(out_ack),
    .o_op(b_op), .o_pc_en(b_pc_en), .o_s_inc(b_s_inc), .o_s_inm(b_s_inm), .o_s_rel(b_s_rel),
    .o_s_ret(b_s_ret), .o_selentrada(b_selin), .o_selsalida(b_selout), .o_we3(b_we3),
    .o_in_ack(b_in_ack), .o_out_en(b_out_en), .o_ret_addr(b_ret), .o_stack_empty(b_empty),
    .o_stack_full(b_full), .o_halted(b_halted), .o_err_code(b_err)
  );

  function automatic logic [14:0] ex(input logic we3, input logic inm, input logic inc,
                                     input logic rel, input logic sin, input logic sout,
                                     input logic ack, input logic pce, input logic [3:0] oe,
                                     input logic [2:0] op);
    return {we3, inm, inc, rel, sin, sout, ack, pce, oe, op};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse reset inside the low clock phase, leaving quiet inputs
  task automatic do_reset();
    opcode = NOP; in_valid = 1'b0; out_ack = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [14:0] act;
    logic [PC_W-1:0] tops [3];

    vecs[0]  = '{6'b000101, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, ex(1,0,1,0,0,0,0,1,4'b0000,3'b101)};
    vecs[1]  = '{6'b001000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, ex(1,1,1,0,0,0,0,1,4'b0000,3'b000)};
    vecs[2]  = '{6'b001010, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, ex(0,0,0,0,0,0,0,1,4'b0000,3'b010)};
    vecs[3]  = '{6'b001010, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, ex(0,0,1,0,0,0,0,1,4'b0000,3'b010)};
    vecs[4]  = '{6'b001011, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, ex(0,0,1,0,0,0,0,1,4'b0000,3'b011)};
    vecs[5]  = '{6'b001011, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, ex(0,0,0,0,0,0,0,1,4'b0000,3'b011)};
    vecs[6]  = '{6'b001001, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, ex(0,0,0,0,0,0,0,1,4'b0000,3'b001)};
    vecs[7]  = '{6'b011001, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, ex(0,0,1,1,0,0,0,1,4'b0000,3'b001)};
    vecs[8]  = '{6'b001100, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, ex(1,0,1,0,1,0,1,1,4'b0000,3'b100)};
    vecs[9]  = '{6'b001101, 1'b0, 2'd2, 2'd1, 1'b0, 1'b1, ex(0,0,1,0,0,1,0,1,4'b0100,3'b101)};
    vecs[10] = '{6'b001110, 1'b0, 2'd3, 2'd0, 1'b0, 1'b1, ex(0,0,1,0,0,0,0,1,4'b1000,3'b110)};
    vecs[11] = '{6'b111111, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, ex(0,0,1,0,0,1,0,1,4'b0010,3'b111)};
    vecs[12] = '{6'b111000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, ex(1,1,1,0,0,0,0,1,4'b0000,3'b000)};
    vecs[13] = '{6'b010111, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, ex(1,0,1,0,0,0,0,1,4'b0000,3'b111)};
    vecs[14] = '{6'b011101, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, ex(0,0,1,0,0,0,0,1,4'b0000,3'b101)};
    vecs[15] = '{6'b101001, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, ex(0,0,1,0,0,0,0,1,4'b0000,3'b001)};

    opcode = ALU; z = 1'b0; p1 = '0; p2 = '0; pc_ret = '0; in_valid = 1'b0; out_ack = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk1("rst_pc_en", a_pc_en, 1'b0);
    chk1("rst_halted", a_halted, 1'b0);
    chkv("rst_err", 32'(a_err), 32'd0);
    chk1("rst_empty", a_empty, 1'b1);
    chk1("rst_full", a_full, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle decode table
    for (int i = 0; i < 16; i++) begin
      opcode = vecs[i].opcode; z = vecs[i].z; p1 = vecs[i].p1; p2 = vecs[i].p2;
      in_valid = vecs[i].in_valid; out_ack = vecs[i].out_ack;
      #1;
      act = {a_we3, a_s_inm, a_s_inc, a_s_rel, a_selin, a_selout, a_in_ack, a_pc_en, a_out_en, a_op};
      chkv($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
      @(negedge clk);
    end
    chk1("table_halted", a_halted, 1'b0);

    // Nested CALL x3; the depth-2 unit overflows on the third
    do_reset();
    opcode = CALL; pc_ret = 10'd5; #1;
    chk1("call1_s_inc", a_s_inc, 1'b0);
    chk1("call1_pc_en", a_pc_en, 1'b1);
    @(negedge clk);
    chkv("call1_top", 32'(a_ret), 32'd5);
    pc_ret = 10'd9;
    @(negedge clk);
    chkv("call2_top", 32'(a_ret), 32'd9);
    chk1("b_full", b_full, 1'b1);
    pc_ret = 10'd12; #1;
    chk1("b_ovf_pc_en", b_pc_en, 1'b0);
    chk1("call3_s_inc", a_s_inc, 1'b0);
    @(negedge clk);
    chkv("call3_top", 32'(a_ret), 32'd12);
    chkv("b_ovf_err", 32'(b_err), 32'd1);
    chk1("b_ovf_halted", b_halted, 1'b1);
    chk1("b_ovf_halt_pc_en", b_pc_en, 1'b0);

    tops[0] = 10'd12; tops[1] = 10'd9; tops[2] = 10'd5;
    opcode = RET;
    for (int i = 0; i < 3; i++) begin
      #1;
      chkv($sformatf("ret%0d_addr", i), 32'(a_ret), 32'(tops[i]));
      chk1($sformatf("ret%0d_s_ret", i), a_s_ret, 1'b1);
      chk1($sformatf("ret%0d_s_inc", i), a_s_inc, 1'b0);
      @(negedge clk);
    end
    chk1("ret_empty", a_empty, 1'b1);
    chk1("ret_not_halted", a_halted, 1'b0);

    // RET on empty stack -> underflow, HALT sticky until reset
    do_reset();
    opcode = RET; #1;
    chk1("unf_pc_en", a_pc_en, 1'b0);
    @(negedge clk);
    chkv("unf_err_a", 32'(a_err), 32'd2);
    chkv("unf_err_b", 32'(b_err), 32'd2);
    chk1("unf_halted", a_halted, 1'b1);
    opcode = ALU; #1;
    chk1("halt_we3", a_we3, 1'b0);
    chk1("halt_pc_en", a_pc_en, 1'b0);
    @(negedge clk);
    chk1("halt_sticky", a_halted, 1'b1);

    // OUT reg port 2, ack on the fourth cycle
    do_reset();
    opcode = OUTR; p1 = 2'd2; p2 = 2'd1;
    for (int c = 0; c < 4; c++) begin
      out_ack = (c == 3);
      #1;
      chkv($sformatf("out_c%0d_en", c), 32'(a_out_en), 32'h4);
      chk1($sformatf("out_c%0d_pc_en", c), a_pc_en, (c == 3));
      @(negedge clk);
    end
    opcode = NOP; out_ack = 1'b0; #1;
    chkv("out_done_en", 32'(a_out_en), 32'h0);
    chk1("out_done_pc_en", a_pc_en, 1'b1);
    chk1("out_done_halted", a_halted, 1'b0);
    @(negedge clk);

    // IN without data: timeout after four stalled cycles on the TIMEOUT=4 unit
    do_reset();
    opcode = IN; in_valid = 1'b0; #1;
    chk1("in_pc_en", a_pc_en, 1'b0);
    chk1("in_selin", a_selin, 1'b1);
    chk1("in_we3", a_we3, 1'b0);
    chk1("in_ack", a_in_ack, 1'b0);
    repeat (4) @(negedge clk);
    chk1("tmo_pre_halted", a_halted, 1'b0);
    chkv("tmo_pre_err", 32'(a_err), 32'd0);
    @(negedge clk);
    chk1("tmo_halted", a_halted, 1'b1);
    chkv("tmo_err", 32'(a_err), 32'd3);
    chk1("tmo_pc_en", a_pc_en, 1'b0);
    chk1("b_no_tmo_halted", b_halted, 1'b0);
    chk1("b_no_tmo_pc_en", b_pc_en, 1'b0);

    // Reset asserted mid-stall with a non-empty stack
    do_reset();
    opcode = CALL; pc_ret = 10'd7;
    @(negedge clk);
    chk1("pre_stall_nonempty", a_empty, 1'b0);
    opcode = IN; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0; #1;
    chk1("midrst_empty", a_empty, 1'b1);
    chk1("midrst_halted", a_halted, 1'b0);
    chkv("midrst_err", 32'(a_err), 32'd0);
    chk1("midrst_pc_en", a_pc_en, 1'b0);
    rst_n = 1'b1;
    in_valid = 1'b1; #1;
    chk1("postrst_in_ack", a_in_ack, 1'b1);
    chk1("postrst_pc_en", a_pc_en, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk1("postrst_tmo_pre", a_halted, 1'b0);
    @(negedge clk);
    chk1("postrst_tmo", a_halted, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
